hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_fwd_sel.sv | 28 ++
 rtl/hazard_scoreboard.sv | 150 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: stage-entry record,
// forwarding/tuse constants and the register-match rule.
package hazard_pkg;

  // Storage width for tnew inside a stage entry; TW-wide inputs are zero-extended.
  localparam int unsigned TNEW_W    = 8;
  // Forwarding code meaning "take the register-file / latched value".
  localparam int unsigned FW_RF     = 0;
  // Tuse value meaning the operand is not read.
  localparam int unsigned TUSE_NONE = 4;

  typedef struct packed {
    logic [4:0]        a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic              md;
  } hz_entry_t;

  // A stage produces register r only if it writes a nonzero destination equal to r.
  function automatic logic hz_match(logic [4:0] a3, logic we, logic [4:0] r);
    return we && (a3 == r) && (a3 != 5'd0);
  endfunction

  // Advance an entry one stage: tnew counts down and sticks at zero.
  function automatic hz_entry_t hz_age(hz_entry_t e);
    hz_entry_t a;
    a = e;
    if (a.tnew != '0) a.tnew = a.tnew - 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request / hazard-response bundle between the pipeline and the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned TW = 3,
  parameter int unsigned FW = 2
);
  logic [4:0]    rs_d;
  logic [4:0]    rt_d;
  logic [TW-1:0] tuse_rs_d;
  logic [TW-1:0] tuse_rt_d;
  logic [4:0]    a3_d;
  logic          we_d;
  logic [TW-1:0] tnew_d;
  logic          md_d;
  logic          mduse_d;
  logic          flush;
  logic          stall;
  logic [FW-1:0] fwd_rs_d;
  logic [FW-1:0] fwd_rt_d;
  logic [FW-1:0] fwd_rs_e;
  logic [FW-1:0] fwd_rt_e;
  logic          md_busy;

  // Pipeline side: presents the D instruction, consumes hazard decisions.
  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, we_d, tnew_d, md_d, mduse_d, flush,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

  // Scoreboard side.
  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_d, we_d, tnew_d, md_d, mduse_d, flush,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Picks the youngest (lowest-index) stage writing the source register; forwards
// only if that stage already has its result (tnew==0), otherwise falls back to RF.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned NENT  = 3,
  parameter int unsigned FW    = 2,
  parameter int unsigned FIRST = 0  // stage index of ent 0, so code = FIRST + i + 1
) (
  input  logic [4:0]    src_i,
  input  logic [4:0]    a3_i [NENT],
  input  logic          we_i [NENT],
  input  logic          tz_i [NENT],
  output logic [FW-1:0] sel_o
);

  // Scan oldest to youngest so the youngest match overrides; a not-ready young
  // match therefore masks any older ready one.
  always_comb begin
    sel_o = FW'(FW_RF);
    for (int i = int'(NENT) - 1; i >= 0; i--) begin
      if (hz_match(a3_i[i], we_i[i], src_i)) begin
        sel_o = tz_i[i] ? FW'(FIRST + 32'(i) + 1) : FW'(FW_RF);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard: tracks E/M/W destination info, raises stall and
// selects forwarding sources for the D and E operands, and times mult/div busy.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned TW     = 3,
  parameter int unsigned MD_LAT = 5,
  parameter int unsigned FW     = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned CW = $clog2(MD_LAT + 1);

  hz_entry_t     ent_q [NSTAGE];
  hz_entry_t     ent_d [NSTAGE];
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  logic          stall_rs, stall_rt, stall_md, stall, md_busy;

  logic [4:0]    a3_all [NSTAGE];
  logic          we_all [NSTAGE];
  logic          tz_all [NSTAGE];
  logic [4:0]    a3_old [NSTAGE-1];
  logic          we_old [NSTAGE-1];
  logic          tz_old [NSTAGE-1];

  logic [FW-1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  assign md_busy = (md_cnt_q != '0);

  // Stall when any in-flight producer delivers later than the D operand needs it,
  // or when HI/LO is touched while a mult/div is issuing or running.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    for (int k = 0; k < int'(NSTAGE); k++) begin
      if (hz_match(ent_q[k].a3, ent_q[k].we, bus.rs_d) &&
          (bus.tuse_rs_d != TW'(TUSE_NONE)) &&
          (ent_q[k].tnew > TNEW_W'(bus.tuse_rs_d))) begin
        stall_rs = 1'b1;
      end
      if (hz_match(ent_q[k].a3, ent_q[k].we, bus.rt_d) &&
          (bus.tuse_rt_d != TW'(TUSE_NONE)) &&
          (ent_q[k].tnew > TNEW_W'(bus.tuse_rt_d))) begin
        stall_rt = 1'b1;
      end
    end
    stall_md = bus.mduse_d & (ent_q[0].md | md_busy);
    stall    = stall_rs | stall_rt | stall_md;
  end

  // Flatten entry fields for the selectors: all stages for D, stages 1.. for E.
  always_comb begin
    for (int k = 0; k < int'(NSTAGE); k++) begin
      a3_all[k] = ent_q[k].a3;
      we_all[k] = ent_q[k].we;
      tz_all[k] = (ent_q[k].tnew == '0);
    end
    for (int k = 0; k < int'(NSTAGE) - 1; k++) begin
      a3_old[k] = ent_q[k+1].a3;
      we_old[k] = ent_q[k+1].we;
      tz_old[k] = (ent_q[k+1].tnew == '0);
    end
  end

  // Next pipeline contents: D enters E unless stalled/flushed; older stages age.
  always_comb begin
    ent_d[0] = '0;
    if (!stall && !bus.flush) begin
      ent_d[0].a3   = bus.a3_d;
      ent_d[0].we   = bus.we_d;
      ent_d[0].tnew = TNEW_W'(bus.tnew_d);
      ent_d[0].rs   = bus.rs_d;
      ent_d[0].rt   = bus.rt_d;
      ent_d[0].md   = bus.md_d;
    end
    for (int k = 1; k < int'(NSTAGE); k++) begin
      ent_d[k] = hz_age(ent_q[k-1]);
    end
  end

  // Mult/div busy counter: issue in E reloads, otherwise count down to idle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (ent_q[0].md) begin
      md_cnt_d = CW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // State registers; reset wipes every in-flight instruction and the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(NSTAGE); k++) begin
        ent_q[k] <= '0;
      end
      md_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(NSTAGE); k++) begin
        ent_q[k] <= ent_d[k];
      end
      md_cnt_q <= md_cnt_d;
    end
  end

  hazard_fwd_sel #(.NENT(NSTAGE), .FW(FW), .FIRST(0)) u_fwd_rs_d (
    .src_i (bus.rs_d),
    .a3_i  (a3_all),
    .we_i  (we_all),
    .tz_i  (tz_all),
    .sel_o (fwd_rs_d)
  );

  hazard_fwd_sel #(.NENT(NSTAGE), .FW(FW), .FIRST(0)) u_fwd_rt_d (
    .src_i (bus.rt_d),
    .a3_i  (a3_all),
    .we_i  (we_all),
    .tz_i  (tz_all),
    .sel_o (fwd_rt_d)
  );

  hazard_fwd_sel #(.NENT(NSTAGE - 1), .FW(FW), .FIRST(1)) u_fwd_rs_e (
    .src_i (ent_q[0].rs),
    .a3_i  (a3_old),
    .we_i  (we_old),
    .tz_i  (tz_old),
    .sel_o (fwd_rs_e)
  );

  hazard_fwd_sel #(.NENT(NSTAGE - 1), .FW(FW), .FIRST(1)) u_fwd_rt_e (
    .src_i (ent_q[0].rt),
    .a3_i  (a3_old),
    .we_i  (we_old),
    .tz_i  (tz_old),
    .sel_o (fwd_rt_e)
  );

  assign bus.stall    = stall;
  assign bus.md_busy  = md_busy;
  assign bus.fwd_rs_d = fwd_rs_d;
  assign bus.fwd_rt_d = fwd_rt_d;
  assign bus.fwd_rs_e = fwd_rs_e;
  assign bus.fwd_rt_e = fwd_rt_e;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: cycle-by-cycle instruction table with expected
// hazard outputs, plus hand sequences for mult/div timing and mid-stall reset.
module tb_hazard_scoreboard;

  localparam int MD_LAT = 5;
  localparam int NU     = 4;  // operand not used

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.TW(3), .FW(2)) bus ();

  hazard_scoreboard #(.NSTAGE(3), .TW(3), .MD_LAT(MD_LAT), .FW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string name;
    int    st, f1, f2, f3, f4, bz;
  } exp_t;

  typedef struct {
    string name;
    int    rs, trs, rt, trt, a3, we, tn, fl;
    int    st, f1, f2, f3, f4;
  } vec_t;

  exp_t exp_q [$];
  vec_t tbl [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string nm, int rs, int trs, int rt, int trt, int a3, int we,
                              int tn, int fl, int st, int f1, int f2, int f3, int f4);
    vec_t v;
    v.name = nm; v.rs = rs; v.trs = trs; v.rt = rt; v.trt = trt;
    v.a3 = a3; v.we = we; v.tn = tn; v.fl = fl;
    v.st = st; v.f1 = f1; v.f2 = f2; v.f3 = f3; v.f4 = f4;
    return v;
  endfunction

  task automatic set_d(int rs, int trs, int rt, int trt, int a3, int we, int tn,
                       int md, int mdu, int fl);
    bus.rs_d      = 5'(rs);
    bus.tuse_rs_d = 3'(trs);
    bus.rt_d      = 5'(rt);
    bus.tuse_rt_d = 3'(trt);
    bus.a3_d      = 5'(a3);
    bus.we_d      = 1'(we);
    bus.tnew_d    = 3'(tn);
    bus.md_d      = 1'(md);
    bus.mduse_d   = 1'(mdu);
    bus.flush     = 1'(fl);
  endtask

  task automatic expect_out(string nm, int st, int f1, int f2, int f3, int f4, int bz);
    exp_t e;
    e.name = nm; e.st = st; e.f1 = f1; e.f2 = f2; e.f3 = f3; e.f4 = f4; e.bz = bz;
    exp_q.push_back(e);
  endtask

  task automatic cmp1(string nm, string fld, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = exp_q.pop_front();
    cmp1(e.name, "stall",    int'(bus.stall),    e.st);
    cmp1(e.name, "fwd_rs_d", int'(bus.fwd_rs_d), e.f1);
    cmp1(e.name, "fwd_rt_d", int'(bus.fwd_rt_d), e.f2);
    cmp1(e.name, "fwd_rs_e", int'(bus.fwd_rs_e), e.f3);
    cmp1(e.name, "fwd_rt_e", int'(bus.fwd_rt_e), e.f4);
    cmp1(e.name, "md_busy",  int'(bus.md_busy),  e.bz);
  endtask

  // Outputs sampled on the falling edge; inputs change just after the rising edge.
  task automatic cycle_check();
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //        name      rs trs rt trt a3 we tn fl | st frsd frtd frse frte
    tbl.push_back(mk("lw1",     29, 1,  0, NU, 1, 1, 2, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("addu_s",   1, 1,  3, 1,  2, 1, 1, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk("addu_go",  1, 1,  3, 1,  2, 1, 1, 0,  0, 0, 0, 0, 0));
    // lw has reached W (tnew 0) when addu sits in E
    tbl.push_back(mk("nop_e_w",  0, NU, 0, NU, 0, 0, 0, 0,  0, 0, 0, 3, 0));
    tbl.push_back(mk("addu1",    4, 1,  5, 1,  1, 1, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("beq_s",    1, 0,  0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk("beq_go",   1, 0,  0, 0,  0, 0, 0, 0,  0, 2, 0, 0, 0));
    tbl.push_back(mk("ori0",     0, 1,  0, NU, 0, 1, 1, 0,  0, 0, 0, 3, 0));
    tbl.push_back(mk("rd0_e",    0, 0,  0, 0,  3, 1, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("rd0_m",    0, 0,  0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("x_w1",     6, 1,  7, 1,  1, 1, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("y_w1",     3, 1,  8, 1,  1, 1, 1, 0,  0, 3, 0, 0, 0));
    tbl.push_back(mk("z_rd1",    1, 1,  9, 1,  4, 1, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("nop_e_m",  0, NU, 0, NU, 0, 0, 0, 0,  0, 0, 0, 2, 0));
    tbl.push_back(mk("flushed",  0, NU, 0, NU, 5, 1, 2, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk("rd5",      5, 0,  4, 1,  0, 0, 0, 0,  0, 0, 3, 0, 0));
    tbl.push_back(mk("lw6",      0, NU, 0, NU, 6, 1, 2, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk("rd6_fl",   6, 0,  6, 1,  7, 1, 1, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk("rd6_s",    6, 0,  6, 1,  7, 1, 1, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk("rd6_go",   6, 0,  6, 1,  7, 1, 1, 0,  0, 3, 3, 0, 0));
    tbl.push_back(mk("nop_end",  0, NU, 0, NU, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    // Reset state: nothing in flight, so even a HI/LO reader of $1 sees no hazard.
    reset_n = 1'b0;
    set_d(1, 0, 1, 0, 1, 1, 0, 0, 1, 0);
    #2;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_out();
    set_d(0, NU, 0, NU, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      set_d(tbl[i].rs, tbl[i].trs, tbl[i].rt, tbl[i].trt, tbl[i].a3, tbl[i].we, tbl[i].tn,
            0, 0, tbl[i].fl);
      expect_out(tbl[i].name, tbl[i].st, tbl[i].f1, tbl[i].f2, tbl[i].f3, tbl[i].f4, 0);
      cycle_check();
    end

    // mult then mfhi: stall while mult is in E plus MD_LAT busy cycles.
    set_d(0, NU, 0, NU, 0, 0, 0, 1, 1, 0);
    expect_out("mult", 0, 0, 0, 0, 0, 0);
    cycle_check();
    set_d(0, NU, 0, NU, 8, 1, 1, 0, 1, 0);
    for (int c = 0; c <= MD_LAT + 1; c++) begin
      expect_out($sformatf("mfhi_c%0d", c), (c <= MD_LAT) ? 1 : 0, 0, 0, 0, 0,
                 (c >= 1 && c <= MD_LAT) ? 1 : 0);
      cycle_check();
    end

    // Reset in the middle of a mult/div stall with a ready $10 producer in flight.
    set_d(0, NU, 0, NU, 10, 1, 0, 0, 0, 0);
    expect_out("addu10", 0, 0, 0, 0, 0, 0);
    cycle_check();
    set_d(0, NU, 0, NU, 0, 0, 0, 1, 1, 0);
    expect_out("mult2", 0, 0, 0, 0, 0, 0);
    cycle_check();
    set_d(10, 0, 0, NU, 8, 1, 1, 0, 1, 0);
    expect_out("mfhi2_c0", 1, 2, 0, 0, 0, 0);
    cycle_check();
    expect_out("mfhi2_c1", 1, 3, 0, 0, 0, 1);
    @(negedge clk);
    check_out();
    #1 reset_n = 1'b0;
    #1;
    expect_out("rst_mid", 0, 0, 0, 0, 0, 0);
    check_out();
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("post_rst", 0, 0, 0, 0, 0, 0);
    cycle_check();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
